jk_cmd_driver: RTL

- Command-side counterpart of the team's JK flip-flop: accepts a desired N-bit state and generates J/K command pairs that drive an external bank of WIDTH JK flops to that state.
- Uses the JK excitation table against an internal shadow of the expected flop state.
- After a settle window, reads the flop outputs back through q_fb and reports completion and mismatch.
- Sits between a controller issuing target words and a register bank built from JK cells.

---
 rtl/jk_pkg.sv | 19 +
 rtl/jk_cmd_driver_excite.sv | 21 ++
 rtl/jk_cmd_driver.sv | 102 ++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared JK command codes and the driver FSM state encoding.
package jk_pkg;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // Settle counter width covers SETTLE_CYC up to 15.
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SETTLE = 2'd2,
      CHECK  = 2'd3
   } state_e;

endpackage

// File: rtl/jk_cmd_driver_excite.sv
// Per-bit JK excitation: command that moves one flop from cur to nxt.
// Build option JK_TOGGLE_PREF_EN issues changing bits as toggle instead of set/clear.
module jk_excite
   import jk_pkg::*;
(
   input  logic       cur,
   input  logic       nxt,
   output logic [1:0] jk
);

   always_comb begin
      jk = JK_HOLD;
`ifdef JK_TOGGLE_PREF_EN
      if (cur != nxt) jk = JK_TOGGLE;
`else
      if (!cur && nxt)      jk = JK_SET;
      else if (cur && !nxt) jk = JK_RESET;
`endif
   end

endmodule

// File: rtl/jk_cmd_driver.sv
// Drives a bank of WIDTH external JK flops to a requested word and verifies it by readback.
// Build option JK_TOGGLE_PREF_EN (in jk_excite) selects toggle codes for changing bits.
module jk_cmd_driver
   import jk_pkg::*;
#(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     target,
   output logic [2*WIDTH-1:0]   jk_out,
   input  logic [WIDTH-1:0]     q_fb,
   output logic                 busy,
   output logic                 done,
   output logic                 mismatch
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD =
      (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;

   state_e               state_q, state_d;
   logic [2*WIDTH-1:0]   jk_out_q, jk_out_d;
   logic [WIDTH-1:0]     shadow_q, shadow_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic                 mismatch_q, mismatch_d;
   logic [2*WIDTH-1:0]   codes_c;

   // Command pair per bit from the expected flop state towards the target.
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      jk_excite u_excite (
         .cur (shadow_q[i]),
         .nxt (target[i]),
         .jk  (codes_c[2*i +: 2])
      );
   end

   always_comb begin
      state_d    = state_q;
      jk_out_d   = '0;
      shadow_d   = shadow_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      mismatch_d = mismatch_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               jk_out_d   = codes_c;
               shadow_d   = target;
               mismatch_d = 1'b0;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (SETTLE_CYC > 0) begin
               cnt_d   = SETTLE_LOAD;
               state_d = SETTLE;
            end else begin
               state_d = CHECK;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) state_d = CHECK;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         CHECK: begin
            done_d     = 1'b1;
            mismatch_d = (q_fb != shadow_q);
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         jk_out_q   <= '0;
         shadow_q   <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         jk_out_q   <= jk_out_d;
         shadow_q   <= shadow_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign jk_out   = jk_out_q;
   assign done     = done_q;
   assign mismatch = mismatch_q;

endmodule
